// File: rtl/atm_keypad_entry.sv
// Keypad front-end for the ATM controller: assembles account, PIN, operation and
// amount from single key presses and hands one request per transaction downstream.
module atm_keypad_entry #(
    parameter int         PIN_DIGITS  = 4,
    parameter int         AMT_DIGITS  = 9,
    parameter logic [7:0] OP_AMT_MASK = 8'b0011_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        req_ready,
    output logic        req_valid,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic [2:0]  operation,
    output logic [31:0] amount,
    output logic [2:0]  entry_state,
    output logic [3:0]  digit_count,
    output logic        err
);

    // Request handshake: req_valid rises when the last ENTER is accepted and stays
    // high with all fields frozen until a rising edge sees req_ready=1; the request
    // is transferred on that edge and req_valid drops in the following cycle.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC   = 3'd1,
        S_PIN   = 3'd2,
        S_OP    = 3'd3,
        S_AMT   = 3'd4,
        S_ISSUE = 3'd5
    } state_t;

    localparam logic [3:0] PIN_MAX = 4'(PIN_DIGITS);
    localparam logic [3:0] AMT_MAX = 4'(AMT_DIGITS);

    localparam logic [3:0] KEY_ENTER  = 4'd10;
    localparam logic [3:0] KEY_CLEAR  = 4'd11;
    localparam logic [3:0] KEY_CANCEL = 4'd12;

    state_t      state_q, state_d;
    logic [3:0]  acc_q, acc_d;
    logic [15:0] pin_q, pin_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] amt_q, amt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        is_digit;
    logic        is_enter;
    logic        is_clear;
    logic        is_cancel;
    logic [19:0] pin_wide;
    logic [35:0] amt_wide;

    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_enter  = key_valid && (key_code == KEY_ENTER);
    assign is_clear  = key_valid && (key_code == KEY_CLEAR);
    assign is_cancel = key_valid && (key_code == KEY_CANCEL);

    // Widened so *10+d cannot wrap before the digit-count limit is checked.
    assign pin_wide = 20'(pin_q) * 20'd10 + 20'(key_code);
    assign amt_wide = 36'(amt_q) * 36'd10 + 36'(key_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            pin_q   <= '0;
            op_q    <= '0;
            amt_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pin_q   <= pin_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        pin_d   = pin_q;
        op_d    = op_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_digit) begin
                    acc_d   = key_code;
                    cnt_d   = 4'd1;
                    state_d = S_ACC;
                end
            end

            S_ACC: begin
                if (is_cancel) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    pin_d   = '0;
                    op_d    = '0;
                    amt_d   = '0;
                    cnt_d   = '0;
                end else if (is_clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (is_digit) begin
                    acc_d = key_code;
                    cnt_d = 4'd1;
                end else if (is_enter) begin
                    if (cnt_q >= 4'd1) begin
                        state_d = S_PIN;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_PIN: begin
                if (is_cancel) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    pin_d   = '0;
                    op_d    = '0;
                    amt_d   = '0;
                    cnt_d   = '0;
                end else if (is_clear) begin
                    pin_d = '0;
                    cnt_d = '0;
                end else if (is_digit) begin
                    if (cnt_q < PIN_MAX) begin
                        pin_d = pin_wide[15:0];
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (is_enter) begin
                    if (cnt_q == PIN_MAX) begin
                        state_d = S_OP;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_OP: begin
                if (is_cancel) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    pin_d   = '0;
                    op_d    = '0;
                    amt_d   = '0;
                    cnt_d   = '0;
                end else if (is_clear) begin
                    op_d  = '0;
                    cnt_d = '0;
                end else if (is_digit) begin
                    if (key_code <= 4'd7) begin
                        op_d  = key_code[2:0];
                        cnt_d = 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (is_enter) begin
                    if (cnt_q == 4'd0) begin
                        err_d = 1'b1;
                    end else if (OP_AMT_MASK[op_q]) begin
                        state_d = S_AMT;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ISSUE;
                        amt_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end

            S_AMT: begin
                if (is_cancel) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    pin_d   = '0;
                    op_d    = '0;
                    amt_d   = '0;
                    cnt_d   = '0;
                end else if (is_clear) begin
                    amt_d = '0;
                    cnt_d = '0;
                end else if (is_digit) begin
                    if (cnt_q < AMT_MAX) begin
                        amt_d = amt_wide[31:0];
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (is_enter) begin
                    if (cnt_q >= 4'd1) begin
                        state_d = S_ISSUE;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                // Keys are deliberately ignored here so a request can never change under the ATM.
                if (req_ready) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    pin_d   = '0;
                    op_d    = '0;
                    amt_d   = '0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
                pin_d   = '0;
                op_d    = '0;
                amt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign req_valid   = (state_q == S_ISSUE);
    assign acc_num     = acc_q;
    assign pin         = pin_q;
    assign operation   = op_q;
    assign amount      = amt_q;
    assign entry_state = state_q;
    assign digit_count = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed bench for atm_keypad_entry: key sequences with hand-computed request fields.
module tb_atm_keypad_entry;

    localparam int K_ENT = 10;
    localparam int K_CLR = 11;
    localparam int K_CAN = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        req_ready;
    logic        req_valid;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [2:0]  operation;
    logic [31:0] amount;
    logic [2:0]  entry_state;
    logic [3:0]  digit_count;
    logic        err;

    int vectors    = 0;
    int miscompares = 0;

    atm_keypad_entry dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .req_ready   (req_ready),
        .req_valid   (req_valid),
        .acc_num     (acc_num),
        .pin         (pin),
        .operation   (operation),
        .amount      (amount),
        .entry_state (entry_state),
        .digit_count (digit_count),
        .err         (err)
    );

    // Clock and time limit
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drivers: called at a falling edge, return at the next falling edge.
    task automatic press_key(input int code);
        key_valid = 1'b1;
        key_code  = 4'(code);
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'(0);
    endtask

    task automatic press_seq(input int seq[$]);
        foreach (seq[i]) press_key(seq[i]);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic check_fields(input string tag, input int a, input int p, input int o,
                                input longint m);
        check_eq({tag, ".acc"}, 64'(acc_num), 64'(a));
        check_eq({tag, ".pin"}, 64'(pin), 64'(p));
        check_eq({tag, ".op"},  64'(operation), 64'(o));
        check_eq({tag, ".amt"}, 64'(amount), 64'(m));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".state"}, 64'(entry_state), 64'd0);
        check_eq({tag, ".valid"}, 64'(req_valid), 64'd0);
        check_eq({tag, ".count"}, 64'(digit_count), 64'd0);
        check_fields(tag, 0, 0, 0, 0);
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        req_ready = 1'b0;

        // T1: reset with random keys
        @(negedge clk);
        repeat (2) begin
            key_valid = 1'($urandom_range(0, 1));
            key_code  = 4'($urandom_range(0, 15));
            req_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check_idle("t1");
        check_eq("t1.err", 64'(err), 64'd0);
        rst       = 1'b0;
        key_valid = 1'b0;
        req_ready = 1'b0;
        idle_cycle();

        // ENTER in IDLE and ignored codes are no-ops
        press_key(K_ENT);
        check_eq("idle_enter.state", 64'(entry_state), 64'd0);
        check_eq("idle_enter.err", 64'(err), 64'd0);
        press_key(6);
        press_key(14);
        check_eq("ign13.state", 64'(entry_state), 64'd1);
        check_eq("ign13.err", 64'(err), 64'd0);
        check_eq("ign13.acc", 64'(acc_num), 64'd6);
        press_key(K_CAN);
        check_idle("cancel_acc");

        // T2: balance enquiry with ready already high -> single-cycle valid
        req_ready = 1'b1;
        press_seq('{1, K_ENT, 1, 2, 3, 4, K_ENT, 3, K_ENT});
        check_eq("t2.valid", 64'(req_valid), 64'd1);
        check_eq("t2.state", 64'(entry_state), 64'd5);
        check_fields("t2", 1, 1234, 3, 0);
        idle_cycle();
        check_idle("t2.after");
        req_ready = 1'b0;

        // T3: deposit held by back-pressure
        press_seq('{2, K_ENT, 2, 3, 4, 5, K_ENT, 5, K_ENT, 1, 0, 0, 0, K_ENT});
        for (int i = 0; i < 3; i++) begin
            check_eq("t3.valid", 64'(req_valid), 64'd1);
            check_fields("t3", 2, 2345, 5, 1000);
            press_key(7);
        end
        check_eq("t3.valid_end", 64'(req_valid), 64'd1);
        check_eq("t3.err_issue", 64'(err), 64'd0);
        check_fields("t3.end", 2, 2345, 5, 1000);
        req_ready = 1'b1;
        idle_cycle();
        req_ready = 1'b0;
        check_idle("t3.after");

        // T4: rejected keys
        press_seq('{7, K_ENT, 1, 2, K_ENT});
        check_eq("t4.short_pin_err", 64'(err), 64'd1);
        check_eq("t4.short_pin_state", 64'(entry_state), 64'd2);
        check_eq("t4.short_pin_cnt", 64'(digit_count), 64'd2);
        press_key(3);
        check_eq("t4.err_clears", 64'(err), 64'd0);
        press_key(4);
        press_key(5);
        check_eq("t4.pin5_err", 64'(err), 64'd1);
        check_eq("t4.pin5_pin", 64'(pin), 64'd1234);
        press_key(K_ENT);
        press_key(K_ENT);
        check_eq("t4.op_empty_err", 64'(err), 64'd1);
        press_key(9);
        check_eq("t4.op9_err", 64'(err), 64'd1);
        check_eq("t4.op9_state", 64'(entry_state), 64'd3);
        press_seq('{4, K_ENT});
        check_eq("t4.amt_state", 64'(entry_state), 64'd4);
        press_key(K_ENT);
        check_eq("t4.amt_empty_err", 64'(err), 64'd1);
        repeat (9) press_key(9);
        check_eq("t4.amt9", 64'(amount), 64'd999999999);
        check_eq("t4.amt9_err", 64'(err), 64'd0);
        press_key(9);
        check_eq("t4.amt10_err", 64'(err), 64'd1);
        check_eq("t4.amt10_amt", 64'(amount), 64'd999999999);
        press_key(K_ENT);
        check_eq("t4.valid", 64'(req_valid), 64'd1);
        check_fields("t4", 7, 1234, 4, 999999999);
        req_ready = 1'b1;
        idle_cycle();
        req_ready = 1'b0;
        check_idle("t4.after");

        // T5: clear and cancel
        press_seq('{1, K_ENT, 1, 2, K_CLR});
        check_eq("t5.clr_pin", 64'(pin), 64'd0);
        check_eq("t5.clr_cnt", 64'(digit_count), 64'd0);
        check_eq("t5.clr_acc", 64'(acc_num), 64'd1);
        press_seq('{4, 3, 2, 1});
        check_eq("t5.pin", 64'(pin), 64'd4321);
        check_eq("t5.cnt", 64'(digit_count), 64'd4);
        press_seq('{K_ENT, 5, K_ENT, 7});
        check_eq("t5.amt", 64'(amount), 64'd7);
        press_key(K_CAN);
        check_idle("t5.cancel");
        check_eq("t5.cancel_err", 64'(err), 64'd0);

        // T6: reset during ISSUE beats a simultaneous ready
        press_seq('{3, K_ENT, 1, 1, 1, 1, K_ENT, 0, K_ENT});
        check_eq("t6.valid", 64'(req_valid), 64'd1);
        check_fields("t6", 3, 1111, 0, 0);
        rst       = 1'b1;
        req_ready = 1'b1;
        idle_cycle();
        rst       = 1'b0;
        req_ready = 1'b0;
        check_idle("t6.after");
        idle_cycle();
        check_idle("t6.after2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
